tc_avg_filter: RTL and testbench



---
 rtl/tc_pkg.sv | 24 ++
 rtl/tc_alarm_hyst.sv | 47 ++++
 rtl/tc_avg_filter.sv | 190 +++++++++++++++++++
 tb/tb_tc_avg_filter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// ============================================================================
// Module      : tc_pkg
// Description : Shared widths, state encoding and types for the thermocouple
//               averaging filter and its alarm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tc_pkg;

  localparam int TEMP_W    = 20;
  localparam int MAX_LOG2N = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACCUM = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  typedef logic [TEMP_W-1:0] temp_t;

endpackage

`default_nettype wire

// File: rtl/tc_alarm_hyst.sv
// ============================================================================
// Module      : tc_alarm_hyst
// Description : Hysteretic over-threshold flag, evaluated only on i_update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_alarm_hyst #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_avg,
  input  logic         i_update,
  input  logic [W-1:0] i_thresh_hi,
  input  logic [W-1:0] i_thresh_lo,
  output logic         o_alarm
);

  logic alarm_q;
  logic alarm_d;

  // Set is tested first so a misprogrammed hi < lo still raises the alarm.
  always_comb begin
    alarm_d = alarm_q;
    if (i_update) begin
      if (i_avg > i_thresh_hi) begin
        alarm_d = 1'b1;
      end else if (i_avg < i_thresh_lo) begin
        alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign o_alarm = alarm_q;

endmodule

`default_nettype wire

// File: rtl/tc_avg_filter.sv
// ============================================================================
// Module      : tc_avg_filter
// Description : Block-averaging filter (1/2/4/8 samples, round-half-up) with
//               hysteretic over-temperature alarm. Optional min/max tracking
//               of published averages when TC_AVG_MINMAX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_avg_filter #(
  parameter int TEMP_W    = 20,
  parameter int MAX_LOG2N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ena,
  input  logic              i_clear,
  input  logic [1:0]        i_log2n,
  input  logic [TEMP_W-1:0] i_temp,
  input  logic              i_valid,
  input  logic [TEMP_W-1:0] i_thresh_hi,
  input  logic [TEMP_W-1:0] i_thresh_lo,
  output logic [TEMP_W-1:0] o_avg,
  output logic              o_valid,
  output logic              o_alarm,
  output logic              o_busy
`ifdef TC_AVG_MINMAX_EN
  ,
  output logic [TEMP_W-1:0] o_min,
  output logic [TEMP_W-1:0] o_max
`endif
);

  import tc_pkg::*;

  localparam int ACC_W = TEMP_W + MAX_LOG2N;
  localparam int CNT_W = MAX_LOG2N + 1;

  state_t            state_q, state_d;
  logic [1:0]        win_l2_q, win_l2_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TEMP_W-1:0] avg_q, avg_d;
  logic              valid_q, valid_d;

  logic [ACC_W-1:0]  w_temp_ext;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [CNT_W-1:0]  w_count_inc;
  logic [CNT_W-1:0]  w_win_len;
  logic [ACC_W-1:0]  w_rnd;
  logic [ACC_W-1:0]  w_rounded;
  logic              w_done;

  assign w_temp_ext  = {{MAX_LOG2N{1'b0}}, i_temp};
  assign w_acc_sum   = acc_q + w_temp_ext;
  assign w_count_inc = count_q + CNT_W'(1);
  assign w_win_len   = CNT_W'(1) << win_l2_q;
  assign w_done      = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    win_l2_d = win_l2_q;
    acc_d    = acc_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        win_l2_d = i_log2n;
        acc_d    = '0;
        count_d  = '0;
        if (i_ena) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (i_clear) begin
          acc_d    = '0;
          count_d  = '0;
          win_l2_d = i_log2n;
        end else if (i_valid) begin
          acc_d   = w_acc_sum;
          count_d = w_count_inc;
          if (w_count_inc == w_win_len) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A strobe here opens the next window; a 1-sample window completes at once.
        win_l2_d = i_log2n;
        acc_d    = '0;
        count_d  = '0;
        state_d  = S_ACCUM;
        if (!i_clear && i_valid) begin
          acc_d   = w_temp_ext;
          count_d = CNT_W'(1);
          if (i_log2n == 2'd0) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!i_ena) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
    end
  end

  // The average is registered on the edge that completes the window, so it is
  // already visible on o_avg while o_valid is high in the DONE cycle.
  always_comb begin
    w_rnd     = (ACC_W'(1) << win_l2_d) >> 1;
    w_rounded = (acc_d + w_rnd) >> win_l2_d;
    valid_d   = (state_d == S_DONE);
    avg_d     = avg_q;
    if (valid_d) begin
      avg_d = TEMP_W'(w_rounded);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      win_l2_q <= 2'd0;
      acc_q    <= '0;
      count_q  <= '0;
      avg_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_l2_q <= win_l2_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      avg_q    <= avg_d;
      valid_q  <= valid_d;
    end
  end

  tc_alarm_hyst #(
    .W (TEMP_W)
  ) u_alarm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_avg       (avg_q),
    .i_update    (w_done),
    .i_thresh_hi (i_thresh_hi),
    .i_thresh_lo (i_thresh_lo),
    .o_alarm     (o_alarm)
  );

`ifdef TC_AVG_MINMAX_EN
  logic [TEMP_W-1:0] min_q, min_d;
  logic [TEMP_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (i_clear) begin
      min_d = '1;
      max_d = '0;
    end else if (valid_d) begin
      if (avg_d < min_q) min_d = avg_d;
      if (avg_d > max_q) max_d = avg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign o_min = min_q;
  assign o_max = max_q;
`endif

  assign o_avg   = avg_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q == S_ACCUM) && (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_tc_avg_filter.sv
// ============================================================================
// Module      : tb_tc_avg_filter
// Description : Directed self-checking bench for tc_avg_filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tc_avg_filter;

  localparam int TW = 20;

  logic          clk;
  logic          rst_n;
  logic          i_ena;
  logic          i_clear;
  logic [1:0]    i_log2n;
  logic [TW-1:0] i_temp;
  logic          i_valid;
  logic [TW-1:0] i_thresh_hi;
  logic [TW-1:0] i_thresh_lo;
  logic [TW-1:0] o_avg;
  logic          o_valid;
  logic          o_alarm;
  logic          o_busy;
`ifdef TC_AVG_MINMAX_EN
  logic [TW-1:0] o_min;
  logic [TW-1:0] o_max;
`endif

  int n_checks;
  int n_pass;

  tc_avg_filter #(
    .TEMP_W    (TW),
    .MAX_LOG2N (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ena       (i_ena),
    .i_clear     (i_clear),
    .i_log2n     (i_log2n),
    .i_temp      (i_temp),
    .i_valid     (i_valid),
    .i_thresh_hi (i_thresh_hi),
    .i_thresh_lo (i_thresh_lo),
    .o_avg       (o_avg),
    .o_valid     (o_valid),
    .o_alarm     (o_alarm),
    .o_busy      (o_busy)
`ifdef TC_AVG_MINMAX_EN
    ,
    .o_min       (o_min),
    .o_max       (o_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: drive on the falling edge, return on the next one.
  task automatic pulse(input logic [TW-1:0] t);
    i_temp  = t;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (o_avg !== '0) $display("FAIL reset_avg: got %h want 0", o_avg); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
    n_checks++; if (o_alarm !== 1'b0) $display("FAIL reset_alarm: got %b want 0", o_alarm); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_window1();
    pulse(20'h01234);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL win1_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'h01234) $display("FAIL win1_avg: got %h want 01234", o_avg); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL win1_valid_drop: got %b want 0", o_valid); else n_pass++;
  endtask

  task automatic test_window4();
    i_log2n = 2'd2;
    do_clear();
    pulse(20'd100);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL win4_early1: got %b want 0", o_valid); else n_pass++;
    pulse(20'd101);
    pulse(20'd102);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL win4_early3: got %b want 0", o_valid); else n_pass++;
    n_checks++; if (o_busy !== 1'b1) $display("FAIL win4_busy: got %b want 1", o_busy); else n_pass++;
    pulse(20'd104);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL win4_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'd102) $display("FAIL win4_avg: got %0d want 102", o_avg); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL win4_single: got %b want 0", o_valid); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL win4_busy_end: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_max_and_switch();
    i_log2n = 2'd3;
    do_clear();
    for (int k = 1; k <= 8; k++) begin
      pulse(20'hFFFFF);
      if (k == 4) i_log2n = 2'd1;
      if (k == 7) begin
        n_checks++; if (o_valid !== 1'b0) $display("FAIL max_early7: got %b want 0", o_valid); else n_pass++;
      end
    end
    n_checks++; if (o_valid !== 1'b1) $display("FAIL max_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'hFFFFF) $display("FAIL max_avg: got %h want fffff", o_avg); else n_pass++;
    // First sample lands in the DONE cycle and opens a 2-sample window.
    pulse(20'd10);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL win2_early: got %b want 0", o_valid); else n_pass++;
    pulse(20'd13);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL win2_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'd12) $display("FAIL win2_avg: got %0d want 12", o_avg); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_alarm();
    logic [TW-1:0] avgs [5];
    logic          exp_alarm [5];
    avgs = '{20'd950, 20'd1001, 20'd950, 20'd899, 20'd950};
    exp_alarm = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    i_thresh_hi = 20'd1000;
    i_thresh_lo = 20'd900;
    i_log2n = 2'd0;
    do_clear();
    for (int k = 0; k < 5; k++) begin
      pulse(avgs[k]);
      @(negedge clk);
      n_checks++;
      if (o_alarm !== exp_alarm[k])
        $display("FAIL alarm_%0d: avg %0d got %b want %b", k, avgs[k], o_alarm, exp_alarm[k]);
      else n_pass++;
    end
    i_thresh_hi = 20'd100;
    i_thresh_lo = 20'd200;
    pulse(20'd150);
    @(negedge clk);
    n_checks++; if (o_alarm !== 1'b1) $display("FAIL alarm_misprog: got %b want 1", o_alarm); else n_pass++;
    i_thresh_hi = 20'hFFFFF;
    i_thresh_lo = 20'd0;
  endtask

  task automatic test_clear();
    i_log2n = 2'd2;
    do_clear();
    pulse(20'd10);
    pulse(20'd20);
    i_temp  = 20'd30;
    i_valid = 1'b1;
    i_clear = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_clear = 1'b0;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL clear_busy: got %b want 0", o_busy); else n_pass++;
    pulse(20'd40);
    pulse(20'd50);
    pulse(20'd60);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL clear_early: got %b want 0", o_valid); else n_pass++;
    pulse(20'd70);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL clear_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'd55) $display("FAIL clear_avg: got %0d want 55", o_avg); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    i_log2n = 2'd0;
    do_clear();
    i_temp  = 20'd5;
    i_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL b2b_valid1: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'd5) $display("FAIL b2b_avg1: got %0d want 5", o_avg); else n_pass++;
    i_temp = 20'd7;
    @(negedge clk);
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1) $display("FAIL b2b_valid2: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'd7) $display("FAIL b2b_avg2: got %0d want 7", o_avg); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL b2b_drop: got %b want 0", o_valid); else n_pass++;
  endtask

  task automatic test_enable();
    i_log2n = 2'd0;
    do_clear();
    pulse(20'd77);
    i_log2n = 2'd2;
    do_clear();
    pulse(20'd8);
    pulse(20'd8);
    i_ena = 1'b0;
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL ena_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (o_avg !== 20'd77) $display("FAIL ena_hold_avg: got %0d want 77", o_avg); else n_pass++;
    i_ena = 1'b1;
    @(negedge clk);
    pulse(20'd1);
    pulse(20'd2);
    pulse(20'd3);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL ena_early: got %b want 0", o_valid); else n_pass++;
    pulse(20'd4);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL ena_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_avg !== 20'd3) $display("FAIL ena_avg: got %0d want 3", o_avg); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    i_thresh_hi = 20'd1000;
    i_thresh_lo = 20'd900;
    i_log2n = 2'd0;
    do_clear();
    pulse(20'd2000);
    @(negedge clk);
    n_checks++; if (o_alarm !== 1'b1) $display("FAIL rst_pre_alarm: got %b want 1", o_alarm); else n_pass++;
    i_log2n = 2'd2;
    do_clear();
    pulse(20'd500);
    pulse(20'd500);
    n_checks++; if (o_busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", o_busy); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (o_avg !== '0) $display("FAIL rst_mid_avg: got %h want 0", o_avg); else n_pass++;
    n_checks++; if (o_alarm !== 1'b0) $display("FAIL rst_mid_alarm: got %b want 0", o_alarm); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", o_valid); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    i_ena       = 1'b0;
    i_clear     = 1'b0;
    i_log2n     = 2'd0;
    i_temp      = '0;
    i_valid     = 1'b0;
    i_thresh_hi = 20'hFFFFF;
    i_thresh_lo = 20'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    i_ena = 1'b1;
    @(negedge clk);
    test_window1();
    test_window4();
    test_max_and_switch();
    test_alarm();
    test_clear();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
